// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package piso_pkg;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/piso_bit_cnt.sv
// Mod-WIDTH bit counter: counts shifted bits, flags the last bit of a frame.
module piso_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/piso_tx.sv
// Serializer: accepts a WIDTH-bit word on a valid/ready handshake and shifts it
// out one bit per enabled cycle, then pulses done for one cycle.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sd,
    output logic             sd_valid,
    output logic             frame,
    output logic             done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             accept, adv, last_bit;

    assign accept = load_valid && (state_q != SHIFT);
    assign adv    = (state_q == SHIFT) && shift_en;

    piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk_i (clk),
        .rst_i (r),
        .clr_i (accept),
        .en_i  (adv),
        .tc_o  (last_bit)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_valid) begin
                    sreg_d  = load_data;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    // Head bit falls off the end; zeros fill behind it.
                    sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg_q[WIDTH-1:1]};
                    if (last_bit) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    assign load_ready = (state_q != SHIFT);
    assign sd_valid   = (state_q == SHIFT);
    assign frame      = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign sd         = (state_q == SHIFT) && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
endmodule
